// File: rtl/adc_dual_acq_sched_pkg.sv
// Shared definitions for the dual-ADC acquisition scheduler: default widths,
// byte-split constants and FSM state codes.
package adc_dual_acq_sched_pkg;

  localparam int DEF_SAMPLE_W = 12;
  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_NSAMP_W  = 12;

  // A 12-bit sample is stored as a low byte [7:0] and a zero-padded high byte.
  localparam int LO_MSB = 7;
  localparam int HI_PAD = 4;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE = 4'd0;
  localparam state_t ST_REQ  = 4'd1;
  localparam state_t ST_WAIT = 4'd2;
  localparam state_t ST_WR1L = 4'd3;
  localparam state_t ST_WR1H = 4'd4;
  localparam state_t ST_WR2L = 4'd5;
  localparam state_t ST_WR2H = 4'd6;
  localparam state_t ST_NEXT = 4'd7;
  localparam state_t ST_DONE = 4'd8;

endpackage

// File: rtl/adc_dual_acq_sched_if.sv
// ADC reader handshake plus BRAM write bus seen by the acquisition scheduler.
// master = scheduler, slave = ADC readers / BRAM side.
interface adc_dual_acq_sched_if
  import adc_dual_acq_sched_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int ADDR_W   = DEF_ADDR_W
);
  logic                reqAdc1;
  logic                reqAdc2;
  logic                readyAdc1;
  logic                readyAdc2;
  logic [SAMPLE_W-1:0] dataAdc1;
  logic [SAMPLE_W-1:0] dataAdc2;
  logic [ADDR_W-1:0]   busBramAddr;
  logic [7:0]          busBramOut;
  logic                ctrlWeBram;

  modport master (
    output reqAdc1, reqAdc2, busBramAddr, busBramOut, ctrlWeBram,
    input  readyAdc1, readyAdc2, dataAdc1, dataAdc2
  );

  modport slave (
    input  reqAdc1, reqAdc2, busBramAddr, busBramOut, ctrlWeBram,
    output readyAdc1, readyAdc2, dataAdc1, dataAdc2
  );
endinterface

// File: rtl/adc_dual_acq_sched_sample_hold.sv
// adc_sample_hold: one-sample holding register for an ADC channel. Captures on
// ready when empty (or being released the same cycle); a ready that finds the
// register occupied is dropped and reported with a one-cycle drop pulse.
module adc_sample_hold
  import adc_dual_acq_sched_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic                ready,
  input  logic [SAMPLE_W-1:0] data,
  input  logic                rel,
  output logic                full,
  output logic [SAMPLE_W-1:0] q,
  output logic                drop
);

  // A strobe arriving while the held sample is still pending is lost.
  assign drop = en && ready && full && !rel;

  // Capture / release of the held sample.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      full <= 1'b0;
      q    <= '0;
    end else if (en && ready && (!full || rel)) begin
      full <= 1'b1;
      q    <= data;
    end else if (rel) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_dual_acq_sched.sv
// adc_dual_acq_sched: requests conversions from ADC1 (and ADC2 in dual mode),
// holds each result, and writes it as two bytes into the comm BRAM, ADC1 first.
// Optional feature: define ACQ_TIMEOUT_EN to add a WAIT-state timeout
// (parameter TIMEOUT_CYC, sticky output timeout).
module adc_dual_acq_sched
  import adc_dual_acq_sched_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NSAMP_W  = DEF_NSAMP_W
`ifdef ACQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4095
`endif
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               modeAdc,
  input  logic [NSAMP_W-1:0] nSamples,
  adc_dual_acq_sched_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  output logic               trunc
`ifdef ACQ_TIMEOUT_EN
  , output logic             timeout
`endif
);

  state_t              state;
  state_t              wr_next;
  logic                mode_r;
  logic [NSAMP_W-1:0]  nsamp_r;
  logic [NSAMP_W-1:0]  count_r;
  logic [NSAMP_W-1:0]  count_nxt;
  logic [ADDR_W-1:0]   addr_r;
  logic                full1, full2, drop1, drop2, rel1, rel2, group_ready;
  logic [SAMPLE_W-1:0] q1, q2;
  logic [7:0]          wr_byte;
  logic                is_wr;

  // Holds are flushed in DONE so a partial group never leaks into the next run.
  assign rel1 = (state == ST_WR1H) || (state == ST_DONE);
  assign rel2 = (state == ST_WR2H) || (state == ST_DONE);

  adc_sample_hold #(.SAMPLE_W(SAMPLE_W)) u_hold1 (
    .clk(clk), .rstn(rstn), .en(state != ST_IDLE), .ready(bus.readyAdc1),
    .data(bus.dataAdc1), .rel(rel1), .full(full1), .q(q1), .drop(drop1)
  );

  adc_sample_hold #(.SAMPLE_W(SAMPLE_W)) u_hold2 (
    .clk(clk), .rstn(rstn), .en((state != ST_IDLE) && mode_r), .ready(bus.readyAdc2),
    .data(bus.dataAdc2), .rel(rel2), .full(full2), .q(q2), .drop(drop2)
  );

  // Looking at the incoming strobe lets the first write follow ready by one cycle.
  assign group_ready = (full1 || bus.readyAdc1) && (!mode_r || full2 || bus.readyAdc2);
  assign count_nxt   = count_r + NSAMP_W'(1);

  assign bus.reqAdc1     = (state == ST_REQ);
  assign bus.reqAdc2     = (state == ST_REQ) && mode_r;
  assign bus.busBramAddr = addr_r;
  assign bus.busBramOut  = wr_byte;
  assign bus.ctrlWeBram  = is_wr;

  // Byte select and successor state for the write states.
  always_comb begin
    wr_byte = 8'h00;
    is_wr   = 1'b1;
    wr_next = ST_NEXT;
    case (state)
      ST_WR1L: begin wr_byte = q1[LO_MSB:0]; wr_next = ST_WR1H; end
      ST_WR1H: begin wr_byte = {{HI_PAD{1'b0}}, q1[SAMPLE_W-1:LO_MSB+1]};
                     wr_next = mode_r ? ST_WR2L : ST_NEXT; end
      ST_WR2L: begin wr_byte = q2[LO_MSB:0]; wr_next = ST_WR2H; end
      ST_WR2H: begin wr_byte = {{HI_PAD{1'b0}}, q2[SAMPLE_W-1:LO_MSB+1]}; end
      default: is_wr = 1'b0;
    endcase
  end

`ifdef ACQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;

  // Cycles spent waiting for the current sample group.
  always_ff @(posedge clk) begin
    if (!rstn || state != ST_WAIT) tcnt <= '0;
    else                           tcnt <= tcnt + TW'(1);
  end
`endif

  // Acquisition sequencer with status flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      mode_r  <= 1'b0;
      nsamp_r <= '0;
      count_r <= '0;
      addr_r  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      trunc   <= 1'b0;
`ifdef ACQ_TIMEOUT_EN
      timeout <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (drop1 || drop2) overrun <= 1'b1;
      case (state)
        ST_IDLE: if (start) begin
          mode_r  <= modeAdc;
          nsamp_r <= nSamples;
          count_r <= '0;
          addr_r  <= '0;
          overrun <= 1'b0;
          trunc   <= 1'b0;
`ifdef ACQ_TIMEOUT_EN
          timeout <= 1'b0;
`endif
          busy    <= 1'b1;
          state   <= (nSamples == '0) ? ST_DONE : ST_REQ;
        end
        ST_REQ:  state <= ST_WAIT;
        ST_WAIT: begin
          if (group_ready) state <= ST_WR1L;
`ifdef ACQ_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            timeout <= 1'b1;
            state   <= ST_DONE;
          end
`endif
        end
        ST_WR1L, ST_WR1H, ST_WR2L, ST_WR2H: begin
          // The last BRAM byte ends the run; the address never wraps.
          if (&addr_r) begin
            trunc <= 1'b1;
            state <= ST_DONE;
          end else begin
            addr_r <= addr_r + ADDR_W'(1);
            state  <= wr_next;
          end
        end
        ST_NEXT: begin
          count_r <= count_nxt;
          state   <= (count_nxt == nsamp_r) ? ST_DONE : ST_REQ;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_dual_acq_sched.sv
// Bench for adc_dual_acq_sched: behavioural ADC responders with random latency
// and data, a BRAM write monitor, and an expected byte image built from the
// samples each responder actually delivered.
module tb_adc_dual_acq_sched;
  import adc_dual_acq_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        modeAdc = 1'b0;
  logic [11:0] nSamples = '0;
  logic        busy, done, overrun, trunc;
`ifdef ACQ_TIMEOUT_EN
  logic        timeout;
`endif

  adc_dual_acq_sched_if ifc ();

`ifdef ACQ_TIMEOUT_EN
  adc_dual_acq_sched #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .modeAdc(modeAdc), .nSamples(nSamples),
    .bus(ifc), .busy(busy), .done(done), .overrun(overrun), .trunc(trunc),
    .timeout(timeout));
`else
  adc_dual_acq_sched dut (
    .clk(clk), .rstn(rstn), .start(start), .modeAdc(modeAdc), .nSamples(nSamples),
    .bus(ifc), .busy(busy), .done(done), .overrun(overrun), .trunc(trunc));
`endif

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // responder state
  logic [11:0] s1[$], s2[$], fixq1[$];
  int  cnt1 = 0, cnt2 = 0;
  logic [11:0] v1, v2;
  bit  lag_mode = 0, dup_once = 0, dup_arm = 0, silent = 0;

  // monitor state
  int          wr_addr[$];
  logic [7:0]  wr_data[$];
  int          n_done = 0, n_req1 = 0, n_req2 = 0;

  initial begin
    ifc.readyAdc1 = 1'b0; ifc.readyAdc2 = 1'b0;
    ifc.dataAdc1 = '0;    ifc.dataAdc2 = '0;
    forever begin
      @(negedge clk);
      ifc.readyAdc1 = 1'b0;
      ifc.readyAdc2 = 1'b0;
      if (dup_arm) begin
        ifc.readyAdc1 = 1'b1; ifc.dataAdc1 = 12'h0AA; dup_arm = 0;
      end
      if (cnt1 > 0) begin
        cnt1--;
        if (cnt1 == 0) begin
          ifc.readyAdc1 = 1'b1; ifc.dataAdc1 = v1; s1.push_back(v1);
          if (dup_once) begin dup_arm = 1; dup_once = 0; end
        end
      end
      if (cnt2 > 0) begin
        cnt2--;
        if (cnt2 == 0) begin
          ifc.readyAdc2 = 1'b1; ifc.dataAdc2 = v2; s2.push_back(v2);
        end
      end
      if (ifc.reqAdc1 && !silent) begin
        int d2;
        d2 = $urandom_range(1, 3);
        if (fixq1.size() > 0) v1 = fixq1.pop_front();
        else                  v1 = 12'($urandom_range(0, 4095));
        cnt1 = lag_mode ? d2 + 5 : $urandom_range(1, 6);
        if (ifc.reqAdc2) begin
          v2   = 12'($urandom_range(0, 4095));
          cnt2 = lag_mode ? d2 : $urandom_range(1, 6);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ifc.ctrlWeBram) begin
        wr_addr.push_back(int'(ifc.busBramAddr));
        wr_data.push_back(ifc.busBramOut);
      end
      if (done)        n_done++;
      if (ifc.reqAdc1) n_req1++;
      if (ifc.reqAdc2) n_req2++;
    end
  end

  task automatic clear_obs();
    s1.delete(); s2.delete(); wr_addr.delete(); wr_data.delete();
    n_done = 0; n_req1 = 0; n_req2 = 0;
  endtask

  // One full acquisition, then compare against the expected BRAM image.
  task automatic run_acq(input bit m, input int n, input bit exp_ovr, input string tag);
    int cyc, bpg, g, nbytes, errs, first_bad;
    logic [7:0] expb[$];
    clear_obs();
    @(negedge clk);
    modeAdc = m; nSamples = 12'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (n_done == 0 && cyc < 20000) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    n_chk++;
    if (n_done == 0) $display("FAIL %s_done_seen: no done within %0d cycles", tag, cyc);
    else n_pass++;

    bpg = m ? 4 : 2;
    g   = (n < 4096 / bpg) ? n : 4096 / bpg;
    nbytes = g * bpg;
    for (int i = 0; i < g; i++) begin
      logic [11:0] a, b;
      a = (i < s1.size()) ? s1[i] : 12'h000;
      b = (i < s2.size()) ? s2[i] : 12'h000;
      expb.push_back(a[7:0]); expb.push_back({4'h0, a[11:8]});
      if (m) begin expb.push_back(b[7:0]); expb.push_back({4'h0, b[11:8]}); end
    end

    n_chk++;
    if (wr_data.size() !== nbytes)
      $display("FAIL %s_write_count: got %0d want %0d", tag, wr_data.size(), nbytes);
    else n_pass++;

    errs = 0; first_bad = -1;
    for (int i = 0; i < wr_data.size() && i < nbytes; i++)
      if (wr_addr[i] !== i || wr_data[i] !== expb[i]) begin
        errs++; if (first_bad < 0) first_bad = i;
      end
    n_chk++;
    if (errs != 0)
      $display("FAIL %s_bytes: %0d bad, first idx %0d addr %0d data %02h want addr %0d data %02h",
               tag, errs, first_bad, wr_addr[first_bad], wr_data[first_bad], first_bad, expb[first_bad]);
    else n_pass++;

    n_chk++;
    if (n_req1 !== g || n_req2 !== (m ? g : 0))
      $display("FAIL %s_reqs: got %0d/%0d want %0d/%0d", tag, n_req1, n_req2, g, m ? g : 0);
    else n_pass++;

    n_chk++;
    if (n_done !== 1 || busy !== 1'b0)
      $display("FAIL %s_done_busy: done pulses %0d busy %b want 1 and 0", tag, n_done, busy);
    else n_pass++;

    n_chk++;
    if (trunc !== (nbytes == 4096) || overrun !== exp_ovr)
      $display("FAIL %s_flags: trunc %b overrun %b want %b %b", tag, trunc, overrun,
               (nbytes == 4096), exp_ovr);
    else n_pass++;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, done, overrun, trunc, ifc.reqAdc1, ifc.reqAdc2, ifc.ctrlWeBram} !== 7'b0 ||
        ifc.busBramAddr !== 12'h000 || ifc.busBramOut !== 8'h00)
      $display("FAIL reset_outputs: busy%b done%b ovr%b trn%b req%b%b we%b addr%h out%h want all 0",
               busy, done, overrun, trunc, ifc.reqAdc1, ifc.reqAdc2, ifc.ctrlWeBram,
               ifc.busBramAddr, ifc.busBramOut);
    else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_mode();
    fixq1.delete();
    fixq1.push_back(12'hABC); fixq1.push_back(12'h123); fixq1.push_back(12'h7FF);
    run_acq(1'b0, 3, 1'b0, "single");
    n_chk++;
    if (wr_data.size() != 6 || wr_data[0] !== 8'hBC || wr_data[1] !== 8'h0A ||
        wr_data[3] !== 8'h01 || wr_data[5] !== 8'h07)
      $display("FAIL single_known_bytes: got %0d bytes, want BC 0A 23 01 FF 07", wr_data.size());
    else n_pass++;
  endtask

  task automatic test_dual_lag();
    lag_mode = 1;
    run_acq(1'b1, 2, 1'b0, "dual_lag");
    lag_mode = 0;
  endtask

  task automatic test_zero_samples();
    clear_obs();
    @(negedge clk);
    modeAdc = 1'b0; nSamples = 12'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL zero_t1: busy %b done %b want 1 0", busy, done);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b1)
      $display("FAIL zero_t2: busy %b done %b want 0 1", busy, done);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || n_done !== 1 || n_req1 !== 0 || wr_data.size() !== 0)
      $display("FAIL zero_quiet: done %b pulses %0d reqs %0d writes %0d want 0 1 0 0",
               done, n_done, n_req1, wr_data.size());
    else n_pass++;
  endtask

  task automatic test_overrun();
    fixq1.delete();
    fixq1.push_back(12'h555);
    dup_once = 1;
    run_acq(1'b0, 1, 1'b1, "overrun");
    n_chk++;
    if (wr_data.size() < 2 || wr_data[0] !== 8'h55 || wr_data[1] !== 8'h05)
      $display("FAIL overrun_kept_first: got %0d bytes, want 55 05", wr_data.size());
    else n_pass++;
    // next start clears the sticky flag
    run_acq(1'b1, 2, 1'b0, "after_ovr");
  endtask

  task automatic test_random_runs();
    for (int k = 0; k < 4; k++)
      run_acq(1'($urandom_range(0, 1)), $urandom_range(1, 8), 1'b0, $sformatf("rand%0d", k));
  endtask

  task automatic test_trunc();
    run_acq(1'b1, 1100, 1'b0, "trunc");
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_obs();
    @(negedge clk);
    modeAdc = 1'b0; nSamples = 12'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(ifc.ctrlWeBram && ifc.busBramAddr == 12'd1) && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    n_chk++;
    if (cyc >= 200) $display("FAIL midrst_reach_wr1h: not reached in %0d cycles", cyc);
    else n_pass++;
    rstn = 1'b0;
    @(negedge clk);
    n_done = 0;
    n_chk++;
    if ({busy, done, overrun, trunc, ifc.reqAdc1, ifc.reqAdc2, ifc.ctrlWeBram} !== 7'b0 ||
        ifc.busBramAddr !== 12'h000 || ifc.busBramOut !== 8'h00)
      $display("FAIL midrst_outputs: busy%b done%b we%b addr%h out%h want all 0",
               busy, done, ifc.ctrlWeBram, ifc.busBramAddr, ifc.busBramOut);
    else n_pass++;
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    n_chk++;
    if (n_done !== 0) $display("FAIL midrst_no_done: got %0d done pulses want 0", n_done);
    else n_pass++;
    run_acq(1'b0, 2, 1'b0, "after_rst");
  endtask

`ifdef ACQ_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    clear_obs();
    silent = 1;
    @(negedge clk);
    modeAdc = 1'b1; nSamples = 12'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (n_done == 0 && cyc < 60) begin @(negedge clk); cyc++; end
    n_chk++;
    if (n_done !== 1 || timeout !== 1'b1 || wr_data.size() !== 0)
      $display("FAIL timeout: done %0d timeout %b writes %0d want 1 1 0",
               n_done, timeout, wr_data.size());
    else n_pass++;
    silent = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_mode();
    test_dual_lag();
    test_zero_samples();
    test_overrun();
    test_random_runs();
    test_trunc();
    test_reset_mid();
`ifdef ACQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
